// File: rtl/connect4_board_engine.sv
// Connect-4 board datapath: gravity drop, through-the-placed-cell win detection, read port.
// Build option LFSR_AUTO_EN: auto-move column is seeded by a free-running LFSR instead of lowest free column.
module connect4_board_engine #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reset_board,
    input  logic            insert_p1,
    input  logic            insert_p2,
    input  logic            auto_move,
    input  logic [2:0]      col_sel,
    input  logic            check_win,
    input  logic [2:0]      rd_row,
    input  logic [2:0]      rd_col,
    output logic [1:0]      rd_cell,
    output logic [COLS-1:0] col_full,
    output logic            insert_ok,
    output logic            insert_err,
    output logic [2:0]      last_row,
    output logic [2:0]      last_col,
    output logic            win_flag,
    output logic [1:0]      winner_id,
    output logic            board_full,
    output logic            draw
);
    localparam int HW    = $clog2(ROWS + 1);
    localparam int PW    = $clog2(ROWS * COLS + 1);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CELLS = ROWS * COLS;

    logic [1:0]    cells  [ROWS][COLS];
    logic [HW-1:0] height [COLS];
    logic [PW-1:0] piece_count;
    logic          armed;

    logic [2:0] tgt_col, tgt_row, auto_col;
    logic [1:0] pcode;
    logic       req, both, tgt_in, accept, reject, win_hit;

    always_comb begin
        for (int c = 0; c < COLS; c++)
            col_full[c] = (height[c] == HW'(ROWS));
    end

    always_comb begin
        rd_cell = 2'b00;
        if (int'(rd_row) < ROWS && int'(rd_col) < COLS)
            rd_cell = cells[rd_row[RW-1:0]][rd_col[CW-1:0]];
    end

    assign draw = board_full & ~win_flag;

`ifdef LFSR_AUTO_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 8'hA5;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Scan upward with wrap from a pseudo-random start column.
    logic       found;
    logic [2:0] ci;
    int         start_c;
    always_comb begin
        auto_col = 3'(COLS);
        found    = 1'b0;
        start_c  = int'(lfsr[2:0]) % COLS;
        ci       = 3'd0;
        for (int i = 0; i < COLS; i++) begin
            ci = 3'((start_c + i) % COLS);
            if (!found && !col_full[ci[CW-1:0]]) begin
                auto_col = ci;
                found    = 1'b1;
            end
        end
    end
`else
    logic [2:0] ci;
    always_comb begin
        auto_col = 3'(COLS);
        ci       = 3'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            ci = 3'(i);
            if (!col_full[ci[CW-1:0]]) auto_col = ci;
        end
    end
`endif

    always_comb begin
        req     = insert_p1 ^ insert_p2;
        both    = insert_p1 & insert_p2;
        pcode   = insert_p1 ? 2'b01 : 2'b10;
        tgt_col = auto_move ? auto_col : col_sel;
        tgt_in  = int'(tgt_col) < COLS;
        tgt_row = tgt_in ? 3'(height[tgt_col[CW-1:0]]) : 3'd0;
        // auto_move already picked a non-full column, so only a manual pick can hit a full one
        accept  = armed && req && !win_flag && !board_full && tgt_in &&
                  !(col_full[tgt_col[CW-1:0]] && !auto_move);
        reject  = armed && (both || (req && !accept));
    end

    // Neighbours are read from the pre-write board; the placed cell itself contributes the leading 1.
    int   dr, dc, r_i, c_i, line_len;
    logic alive;
    always_comb begin
        win_hit  = 1'b0;
        dr       = 0;
        dc       = 0;
        r_i      = 0;
        c_i      = 0;
        line_len = 0;
        alive    = 1'b0;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0:       begin dr = 0; dc = 1;  end
                1:       begin dr = 1; dc = 0;  end
                2:       begin dr = 1; dc = 1;  end
                default: begin dr = 1; dc = -1; end
            endcase
            line_len = 1;
            for (int s = -1; s <= 1; s += 2) begin
                alive = 1'b1;
                for (int k = 1; k < WIN_LEN; k++) begin
                    r_i = int'(tgt_row) + s * k * dr;
                    c_i = int'(tgt_col) + s * k * dc;
                    if (alive && r_i >= 0 && r_i < ROWS && c_i >= 0 && c_i < COLS &&
                        cells[r_i[RW-1:0]][c_i[CW-1:0]] == pcode)
                        line_len = line_len + 1;
                    else
                        alive = 1'b0;
                end
            end
            if (line_len >= WIN_LEN) win_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cells       <= '{default: 2'b00};
            height      <= '{default: '0};
            piece_count <= '0;
            armed       <= 1'b1;
            insert_ok   <= 1'b0;
            insert_err  <= 1'b0;
            last_row    <= 3'd0;
            last_col    <= 3'd0;
            win_flag    <= 1'b0;
            winner_id   <= 2'b00;
            board_full  <= 1'b0;
        end else if (reset_board) begin
            cells       <= '{default: 2'b00};
            height      <= '{default: '0};
            piece_count <= '0;
            armed       <= 1'b1;
            insert_ok   <= 1'b0;
            insert_err  <= 1'b0;
            last_row    <= 3'd0;
            last_col    <= 3'd0;
            win_flag    <= 1'b0;
            winner_id   <= 2'b00;
            board_full  <= 1'b0;
        end else begin
            insert_ok  <= accept;
            insert_err <= reject;
            if (accept) begin
                cells[tgt_row[RW-1:0]][tgt_col[CW-1:0]] <= pcode;
                height[tgt_col[CW-1:0]] <= height[tgt_col[CW-1:0]] + 1'b1;
                piece_count <= piece_count + 1'b1;
                board_full  <= (piece_count + 1'b1) == PW'(CELLS);
                last_row    <= tgt_row;
                last_col    <= tgt_col;
                armed       <= 1'b0;
                if (win_hit) begin
                    win_flag  <= 1'b1;
                    winner_id <= pcode;
                end
            end else if (check_win) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_connect4_board_engine.sv
// Bench for connect4_board_engine: directed game scenarios plus random play against a board-level model.
module tb_connect4_board_engine;
    localparam int ROWS = 6;
    localparam int COLS = 7;

`ifdef LFSR_AUTO_EN
    localparam bit AUTO_OK = 1'b0;
`else
    localparam bit AUTO_OK = 1'b1;
`endif

    logic            clk = 1'b0;
    logic            rst, reset_board, insert_p1, insert_p2, auto_move, check_win;
    logic [2:0]      col_sel, rd_row, rd_col;
    logic [1:0]      rd_cell;
    logic [COLS-1:0] col_full;
    logic            insert_ok, insert_err;
    logic [2:0]      last_row, last_col;
    logic            win_flag;
    logic [1:0]      winner_id;
    logic            board_full, draw;

    connect4_board_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(4)) dut (
        .clk(clk), .rst(rst), .reset_board(reset_board),
        .insert_p1(insert_p1), .insert_p2(insert_p2), .auto_move(auto_move),
        .col_sel(col_sel), .check_win(check_win), .rd_row(rd_row), .rd_col(rd_col),
        .rd_cell(rd_cell), .col_full(col_full), .insert_ok(insert_ok), .insert_err(insert_err),
        .last_row(last_row), .last_col(last_col), .win_flag(win_flag), .winner_id(winner_id),
        .board_full(board_full), .draw(draw)
    );

    always #5 clk = ~clk;

    // Model: plain board of player numbers; heights and wins are derived by scanning it.
    int mb [ROWS][COLS];
    int m_armed, m_ok, m_err, m_win, m_winner, m_lr, m_lc;
    int n_chk = 0, n_fail = 0;
    bit cmp_en = 1'b0;

    function automatic int top_of(int c);
        int n = 0;
        for (int r = 0; r < ROWS; r++) if (mb[r][c] != 0) n++;
        return n;
    endfunction

    function automatic int pieces();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) if (mb[r][c] != 0) n++;
        return n;
    endfunction

    function automatic bit four(int p);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        bit line;
        int rr, cc;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int d = 0; d < 4; d++) begin
                    line = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        rr = r + k * dr[d];
                        cc = c + k * dc[d];
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) line = 1'b0;
                        else if (mb[rr][cc] != p) line = 1'b0;
                    end
                    if (line) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic int auto_pick();
        for (int c = 0; c < COLS; c++) if (top_of(c) < ROWS) return c;
        return COLS;
    endfunction

    function automatic int exp_cell(int r, int c);
        if (r < ROWS && c < COLS) return mb[r][c];
        return 0;
    endfunction

    function automatic logic [COLS-1:0] exp_full_vec();
        logic [COLS-1:0] v = '0;
        for (int c = 0; c < COLS; c++) v[c] = (top_of(c) == ROWS);
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mb[r][c] = 0;
        m_armed = 1; m_ok = 0; m_err = 0; m_win = 0; m_winner = 0; m_lr = 0; m_lc = 0;
    endtask

    task automatic model_step();
        bit acc;
        int p, t, r;
        if (!rst || reset_board) begin
            model_reset();
            return;
        end
        m_ok = 0; m_err = 0; acc = 1'b0;
        if (m_armed != 0 && (insert_p1 || insert_p2)) begin
            if (insert_p1 && insert_p2) m_err = 1;
            else begin
                p = insert_p1 ? 1 : 2;
                t = auto_move ? auto_pick() : int'(col_sel);
                if (m_win != 0 || pieces() == ROWS * COLS || t >= COLS ||
                    (!auto_move && top_of(t) == ROWS))
                    m_err = 1;
                else begin
                    r = top_of(t);
                    mb[r][t] = p;
                    m_lr = r; m_lc = t; m_ok = 1; acc = 1'b1; m_armed = 0;
                    if (four(p)) begin m_win = 1; m_winner = p; end
                end
            end
        end
        if (check_win && !acc) m_armed = 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("insert_ok", 32'(insert_ok), m_ok);
            chk("insert_err", 32'(insert_err), m_err);
            chk("last_row", 32'(last_row), m_lr);
            chk("last_col", 32'(last_col), m_lc);
            chk("win_flag", 32'(win_flag), m_win);
            chk("winner_id", 32'(winner_id), m_winner);
            chk("rd_cell", 32'(rd_cell), exp_cell(int'(rd_row), int'(rd_col)));
            chk("col_full", 32'(col_full), 32'(exp_full_vec()));
            chk("board_full", 32'(board_full), 32'(pieces() == ROWS * COLS));
            chk("draw", 32'(draw), 32'(pieces() == ROWS * COLS && m_win == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        insert_p1 = 1'b0; insert_p2 = 1'b0; auto_move = 1'b0; check_win = 1'b0; reset_board = 1'b0;
    endtask

    task automatic ins(input int p, input int c);
        insert_p1 = (p == 1); insert_p2 = (p == 2); col_sel = 3'(c); auto_move = 1'b0;
        tick();
        idle();
    endtask

    task automatic arm();
        check_win = 1'b1;
        tick();
        check_win = 1'b0;
    endtask

    task automatic peek(input int r, input int c);
        rd_row = 3'(r); rd_col = 3'(c);
        #1;
    endtask

    task automatic clear_board();
        reset_board = 1'b1;
        tick();
        reset_board = 1'b0;
    endtask

    int sp [10] = '{2, 1, 2, 1, 1, 2, 1, 2, 1, 2};
    int sc [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int nz, k;

    initial begin
        rst = 1'b0; col_sel = 3'd0; rd_row = 3'd0; rd_col = 3'd0;
        idle();
        model_reset();
        cmp_en = 1'b1;
        tick(); tick();
        chk("reset_win", 32'(win_flag), 0);
        chk("reset_winner", 32'(winner_id), 0);
        chk("reset_colfull", 32'(col_full), 0);
        rst = 1'b1;
        tick();

        // first insert
        ins(1, 3);
        peek(0, 3);
        chk("t1_ok", 32'(insert_ok), 1);
        chk("t1_cell", 32'(rd_cell), 1);
        chk("t1_last_row", 32'(last_row), 0);
        chk("t1_last_col", 32'(last_col), 3);
        chk("t1_win", 32'(win_flag), 0);
        tick();
        chk("t1_ok_one_cycle", 32'(insert_ok), 0);

        // held request is absorbed until re-armed
        arm();
        insert_p1 = 1'b1; col_sel = 3'd2;
        tick(); tick();
        idle();
        peek(1, 2);
        chk("t2_dropped", 32'(rd_cell), 0);
        chk("t2_no_err", 32'(insert_err), 0);
        peek(0, 2);
        chk("t2_first", 32'(rd_cell), 1);
        arm();
        ins(2, 2);
        peek(1, 2);
        chk("t2_p2_stack", 32'(rd_cell), 2);

        // vertical win for P1
        clear_board();
        for (int i = 0; i < 7; i++) begin
            if (i == 6) chk("t3_no_win_yet", 32'(win_flag), 0);
            ins((i % 2 == 0) ? 1 : 2, (i % 2 == 0) ? 0 : 1);
            if (i == 6) begin
                chk("t3_win", 32'(win_flag), 1);
                chk("t3_winner", 32'(winner_id), 1);
            end
            arm();
        end
        ins(2, 3);
        peek(0, 3);
        chk("t3_after_win_err", 32'(insert_err), 1);
        chk("t3_board_same", 32'(rd_cell), 0);

        // column full and dual request
        clear_board();
        for (int i = 0; i < 6; i++) begin
            ins((i % 2) + 1, 6);
            arm();
        end
        chk("t4_colfull", 32'(col_full), 32'h40);
        ins(1, 6);
        peek(5, 6);
        chk("t4_full_err", 32'(insert_err), 1);
        chk("t4_top_same", 32'(rd_cell), 2);
        insert_p1 = 1'b1; insert_p2 = 1'b1; col_sel = 3'd0;
        tick();
        idle();
        peek(0, 0);
        chk("t4_both_err", 32'(insert_err), 1);
        chk("t4_both_nochange", 32'(rd_cell), 0);

`ifndef LFSR_AUTO_EN
        // auto-move skips full columns
        clear_board();
        for (int i = 0; i < 6; i++) begin
            ins((i % 2) + 1, 0); arm();
            ins((i % 2) + 1, 1); arm();
        end
        insert_p2 = 1'b1; auto_move = 1'b1; col_sel = 3'd0;
        tick();
        idle();
        peek(0, 2);
        chk("t5_auto_cell", 32'(rd_cell), 2);
        chk("t5_auto_col", 32'(last_col), 2);
`endif

        // rising diagonal for P2, then clear
        clear_board();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk("t6_no_win_yet", 32'(win_flag), 0);
            ins(sp[i], sc[i]);
            if (i == 9) begin
                chk("t6_win", 32'(win_flag), 1);
                chk("t6_winner", 32'(winner_id), 2);
            end
            arm();
        end
        clear_board();
        chk("t6_clr_win", 32'(win_flag), 0);
        chk("t6_clr_colfull", 32'(col_full), 0);
        nz = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                peek(r, c);
                if (rd_cell !== 2'b00) nz++;
            end
        chk("t6_clr_cells", nz, 0);

        // random play
        clear_board();
        for (int i = 0; i < 5000; i++) begin
            k = $urandom_range(0, 99);
            insert_p1   = (k < 30);
            insert_p2   = (k >= 26 && k < 56);
            col_sel     = 3'($urandom_range(0, 7));
            auto_move   = AUTO_OK && ($urandom_range(0, 7) == 0);
            check_win   = ($urandom_range(0, 2) == 0);
            reset_board = ($urandom_range(0, 149) == 0);
            rd_row      = 3'($urandom_range(0, 7));
            rd_col      = 3'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/connect4_board_engine.md
Name: connect4_board_engine

Overview:
- Board datapath directly downstream of the game-controller FSM.
- Consumes its insert_piece_p1/insert_piece_p2, check_win and reset_board strobes, plus a timeout-driven auto-move flag.
- Stores the 6x7 grid, drops pieces into the lowest free row, and detects four-in-a-row through the placed cell.
- Returns win_flag/winner_id to the controller, and exposes a cell read port and column-full vector for the VGA and input stages.

Parameters:
- ROWS, 6, board rows; row 0 is the bottom.
- COLS, 7, board columns, at most 8.
- WIN_LEN, 4, consecutive pieces required to win.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- reset_board  in  1  synchronous clear of game state; highest priority
- insert_p1  in  1  request to insert a player-1 piece
- insert_p2  in  1  request to insert a player-2 piece
- auto_move  in  1  qualifies an insert as timeout auto-move; col_sel is ignored
- col_sel  in  3  column chosen by the player
- check_win  in  1  controller is in CHECK_WINNER; re-arms insertion
- rd_row  in  3  read-port row
- rd_col  in  3  read-port column
- rd_cell  out  2  combinational read: 00 empty, 01 P1, 10 P2
- col_full  out  COLS  bit c = 1 when height[c]==ROWS
- insert_ok  out  1  one-cycle pulse, cycle after an accepted insert
- insert_err  out  1  one-cycle pulse, cycle after a rejected insert
- last_row  out  3  row of the last accepted piece
- last_col  out  3  column of the last accepted piece
- win_flag  out  1  sticky win indication
- winner_id  out  2  01 P1, 10 P2, 00 none
- board_full  out  1  all ROWS*COLS cells occupied
- draw  out  1  board_full && !win_flag

Behaviour:
- Reset (rst low, or reset_board high at an edge) puts the block in this state:
  - All cells 00, height[] = 0, piece_count = 0.
  - armed = 1.
  - insert_ok, insert_err, win_flag, board_full, draw = 0; winner_id = 00; last_row, last_col = 0.
- Storage:
  - Cell array is ROWS x COLS x 2 bits.
  - height[c] ranges 0..ROWS.
  - piece_count width is clog2(ROWS*COLS+1).
- Request decode, evaluated each edge when reset_board = 0:
  - req = insert_p1 ^ insert_p2.
  - Both asserted: reject (insert_err) and change nothing.
- Ignore rule: if armed = 0, requests are silently dropped; no ok or err pulse.
  - This absorbs the controller's back-to-back TIMEOUT_ERROR -> PROCESS double strobe.
- Target column:
  - auto_move = 0: col_sel.
  - auto_move = 1: auto column (see Optional Feature).
- Reject conditions, each producing an insert_err pulse with armed unchanged:
  - win_flag = 1.
  - board_full = 1.
  - Target column >= COLS.
  - col_full[target] = 1 with auto_move = 0.
- Accept:
  - Write the player code at (height[t], t); increment height[t] and piece_count.
  - last_row/last_col <= placed position; armed <= 0; insert_ok pulses next cycle.
- Win evaluation happens in the same edge as the accept:
  - Count same-player cells contiguous with the placed cell along four directions: horizontal, vertical, and both diagonals, using the post-write board.
  - If any line total (including the placed cell) >= WIN_LEN: win_flag <= 1 and winner_id <= player.
  - Result is therefore valid the cycle after insert, i.e. while the controller sits in CHECK_WINNER.
- board_full <= (piece_count+1 == ROWS*COLS) on accept.
- win_flag and winner_id are sticky until reset.
- check_win sets armed <= 1, unless an insert is accepted in the same cycle, in which case the insert wins and armed = 0.
- reset_board asserted together with an insert: clear only; the insert is lost.
- Outputs are registered except rd_cell, col_full and draw, which are combinational from state.
- Out-of-range rd_row/rd_col return 00.

Optional Feature:
- Macro: LFSR_AUTO_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at reset) free-runs every cycle.
  - Auto column is the first non-full column scanning upward with wrap from lfsr[2:0] mod COLS.
- Undefined:
  - Auto column is the lowest-index non-full column.
  - No LFSR logic is present.

Test Plan:
- Reset, then insert_p1 col_sel=3 -> next cycle insert_ok=1 for one cycle, rd(0,3)=01, last_row=0, last_col=3, win_flag=0.
- insert_p1 col 2 held two consecutive cycles -> only rd(0,2)=01, no insert_err; after a check_win pulse, insert_p2 col 2 -> rd(1,2)=10.
- Vertical win:
  - Stimulus: alternate P1 col 0 and P2 col 1, each followed by check_win, until P1 has 4 pieces.
  - Response: win_flag=1 and winner_id=01 the cycle after the 7th insert.
  - A further insert after the win gives insert_err=1 and an unchanged board.
- Fill col 6 with 6 inserts -> col_full[6]=1; a 7th insert to col 6 gives insert_err=1, height unchanged; insert_p1 and insert_p2 asserted together also give insert_err=1.
- Macro undefined, cols 0 and 1 full, insert_p2 with auto_move=1 and col_sel=0 -> piece at (0,2)=10.
- Build a P2 rising diagonal (0,0),(1,1),(2,2),(3,3) -> winner_id=10; then reset_board -> next cycle all cells 00, win_flag=0, col_full=0.
